// File: rtl/scan_capture_if.sv
// Row-beat output stream of scan_capture: one captured frame row per valid/ready handshake.
interface scan_capture_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3
);
    logic               out_valid;
    logic               out_ready;
    logic [REGBITS-1:0] out_addr;
    logic [WIDTH-1:0]   out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/scan_capture.sv
// Rebuilds the Game-of-Life frame from the deglitched LED row/col scan and streams it out row by row.
// Optional macro SCAN_ORDER_CHECK_EN: captures must arrive in ascending row order starting at row 0.
module scan_capture #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3,
    parameter int unsigned STABLE  = 2
) (
    input  logic             ph1,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] row,
    input  logic [WIDTH-1:0] col,
    scan_capture_if.master   stream,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic             overflow,
    output logic             scan_err
);
    localparam int unsigned        CW   = 4;
    localparam logic [REGBITS-1:0] LAST = REGBITS'(WIDTH - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0]   s_row, s_col, seen, seen_nx, data_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               captured, captured_nx;
    logic [WIDTH-1:0]   cbuf [WIDTH];
    logic [WIDTH-1:0]   obuf [WIDTH];
    logic [REGBITS-1:0] ptr, ptr_nx, idx, addr_nx;
    logic               same_c, onehot_c, bad_c, cap_c, wr_c, order_err_c;
    logic               complete_c, xfer_c, free_c, load_c;

`ifdef SCAN_ORDER_CHECK_EN
    logic [REGBITS-1:0] exp_idx, exp_nx;
`endif

    // Scan classification, stability counting and single-shot capture decision
    always_comb begin
        same_c   = (row == s_row) && (col == s_col);
        onehot_c = (row != '0) && ((row & (row - WIDTH'(1))) == '0);
        bad_c    = (row != '0) && !onehot_c;
        idx      = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (row[i]) idx = REGBITS'(i);
        end
        if (bad_c)                   cnt_nx = '0;
        else if (!same_c)            cnt_nx = CW'(1);
        else if (cnt < CW'(STABLE))  cnt_nx = cnt + CW'(1);
        else                         cnt_nx = cnt;
        cap_c       = onehot_c && (cnt_nx == CW'(STABLE)) && !(same_c && captured);
        captured_nx = (row != '0) && ((same_c && captured) || cap_c);
    end

    // Frame assembly: completion hand-off and seen-mask update
    always_comb begin
        complete_c  = &seen;
        xfer_c      = stream.out_valid && stream.out_ready;
        free_c      = (state == IDLE) || (xfer_c && (ptr == LAST));
        load_c      = complete_c && free_c;
        seen_nx     = complete_c ? '0 : seen;
        wr_c        = 1'b0;
        order_err_c = 1'b0;
`ifdef SCAN_ORDER_CHECK_EN
        exp_nx = exp_idx;
        if (cap_c) begin
            if (idx == exp_idx) begin
                seen_nx = seen_nx | (WIDTH'(1) << idx);
                exp_nx  = idx + REGBITS'(1);
                wr_c    = 1'b1;
            end else begin
                order_err_c = 1'b1;
                // An out-of-order row 0 still starts the next frame
                if (idx == '0) begin
                    seen_nx = WIDTH'(1);
                    exp_nx  = REGBITS'(1);
                    wr_c    = 1'b1;
                end else begin
                    seen_nx = '0;
                    exp_nx  = '0;
                end
            end
        end
`else
        if (cap_c) begin
            seen_nx = seen_nx | (WIDTH'(1) << idx);
            wr_c    = 1'b1;
        end
`endif
    end

    // Output FSM next state
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if ((state == SEND) && xfer_c) begin
            if (ptr == LAST) state_nx = IDLE;
            else             ptr_nx   = ptr + REGBITS'(1);
        end
        if (load_c) begin
            state_nx = SEND;
            ptr_nx   = '0;
        end
        addr_nx = '0;
        data_nx = '0;
        if (state_nx == SEND) begin
            addr_nx = ptr_nx;
            data_nx = load_c ? cbuf[ptr_nx] : obuf[ptr_nx];
        end
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            s_row            <= '0;
            s_col            <= '0;
            cnt              <= '0;
            captured         <= 1'b0;
            seen             <= '0;
            frame_done       <= 1'b0;
            frame_cnt        <= 8'h00;
            overflow         <= 1'b0;
            scan_err         <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_addr  <= '0;
            stream.out_data  <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cbuf[i] <= '0;
                obuf[i] <= '0;
            end
        end else begin
            s_row    <= row;
            s_col    <= col;
            cnt      <= cnt_nx;
            captured <= captured_nx;
            seen     <= seen_nx;
            if (wr_c) cbuf[idx] <= col;
            if (load_c) begin
                for (int i = 0; i < int'(WIDTH); i++) obuf[i] <= cbuf[i];
                frame_cnt <= frame_cnt + 8'd1;
            end
            frame_done       <= load_c;
            overflow         <= complete_c && !free_c;
            scan_err         <= (bad_c && (row != s_row)) || order_err_c;
            stream.out_valid <= (state_nx == SEND);
            stream.out_addr  <= addr_nx;
            stream.out_data  <= data_nx;
        end
    end

`ifdef SCAN_ORDER_CHECK_EN
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) exp_idx <= '0;
        else          exp_idx <= exp_nx;
    end
`endif
endmodule

// File: tb/tb_scan_capture.sv
// Randomized self-checking bench for scan_capture against a cycle-level frame/queue reference model.
module tb_scan_capture;
    localparam int STABLE = 2;

    logic       ph1 = 1'b0;
    logic       reset_n;
    logic [7:0] row, col;
    logic       frame_done, overflow, scan_err;
    logic [7:0] frame_cnt;

    scan_capture_if #(.WIDTH(8), .REGBITS(3)) intf ();

    scan_capture #(.WIDTH(8), .REGBITS(3), .STABLE(STABLE)) dut (
        .ph1(ph1), .reset_n(reset_n), .row(row), .col(col), .stream(intf),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow), .scan_err(scan_err)
    );

    always #5 ph1 = ~ph1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mcbuf [8];
    logic [7:0] mobuf [8];
    logic [7:0] mseen, mcnt, prow, pcol;
    logic [2:0] mexp;
    int         mpend, run_len, stall_left, ovf_seen;
    logic       exp_done, exp_ovf, exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mcbuf[i] = 8'h00;
            mobuf[i] = 8'h00;
        end
        mseen = 8'h00; mcnt = 8'h00; prow = 8'h00; pcol = 8'h00; mexp = 3'd0;
        mpend = 0; run_len = 0; stall_left = 0;
        exp_done = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
    endtask

    // One clock edge of the frame-level behaviour: handshake, hand-off, then capture
    task automatic model_edge(input logic [7:0] r, input logic [7:0] c, input logic rdy);
        int idx;
        exp_done = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        if (mpend > 0 && rdy) mpend--;
        if (mseen == 8'hFF) begin
            if (mpend == 0) begin
                mobuf = mcbuf; mpend = 8; mcnt++; exp_done = 1'b1;
            end else begin
                exp_ovf = 1'b1;
            end
            mseen = 8'h00;
        end
        run_len = (r == prow && c == pcol) ? run_len + 1 : 1;
        if (r != 8'h00 && $countones(r) != 1 && r != prow) exp_err = 1'b1;
        if ($countones(r) == 1 && run_len == STABLE) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (r[i]) idx = i;
`ifdef SCAN_ORDER_CHECK_EN
            if (idx == int'(mexp)) begin
                mseen[idx] = 1'b1; mcbuf[idx] = c; mexp = 3'((idx + 1) % 8);
            end else begin
                exp_err = 1'b1; mseen = 8'h00; mexp = 3'd0;
                if (idx == 0) begin
                    mseen = 8'h01; mcbuf[0] = c; mexp = 3'd1;
                end
            end
`else
            mseen[idx] = 1'b1;
            mcbuf[idx] = c;
`endif
        end
        prow = r;
        pcol = c;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(intf.out_valid), 32'(mpend > 0));
        if (mpend > 0) begin
            check_eq("out_addr", 32'(intf.out_addr), 32'(8 - mpend));
            check_eq("out_data", 32'(intf.out_data), 32'(mobuf[8 - mpend]));
        end
        check_eq("frame_done", 32'(frame_done), 32'(exp_done));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("scan_err", 32'(scan_err), 32'(exp_err));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(mcnt));
        if (overflow) ovf_seen++;
    endtask

    // mode 0/1: fixed ready, 2: random, 3: stall 5 cycles while beat 3 is presented
    function automatic logic pick_ready(input int mode);
        if (mode == 3) begin
            if (mpend == 5 && stall_left > 0) begin
                stall_left--;
                return 1'b0;
            end
            return 1'b1;
        end
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return mode[0];
    endfunction

    task automatic step(input logic [7:0] r, input logic [7:0] c, input logic rdy);
        row = r; col = c; intf.out_ready = rdy;
        @(posedge ph1);
        model_edge(r, c, rdy);
        #1;
        check_outputs();
    endtask

    task automatic scan_frame(input logic [7:0] base, input int hold, input int mode);
        for (int i = 0; i < 8; i++) begin
            repeat (hold) step(8'(1 << i), base + 8'(i), pick_ready(mode));
        end
    endtask

    task automatic idle(input int n, input int mode);
        repeat (n) step(8'h00, 8'h00, pick_ready(mode));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(intf.out_valid), 0);
        check_eq("rst_addr", 32'(intf.out_addr), 0);
        check_eq("rst_data", 32'(intf.out_data), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_cnt", 32'(frame_cnt), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        check_eq("rst_err", 32'(scan_err), 0);
        for (int i = 0; i < 3; i++) begin
            row = (i % 2 == 0) ? 8'h01 : 8'h00; col = 8'h5A; intf.out_ready = 1'b1;
            @(posedge ph1);
            #1;
            check_eq("rst_hold_valid", 32'(intf.out_valid), 0);
            check_eq("rst_hold_err", 32'(scan_err), 0);
        end
        model_reset();
        row = 8'h00; col = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic random_segments(input int n);
        logic [7:0] r;
        int k;
        for (int s = 0; s < n; s++) begin
            k = $urandom_range(0, 9);
            if (k < 7)       r = 8'(1 << $urandom_range(0, 7));
            else if (k == 7) r = 8'h00;
            else begin
                r = 8'($urandom);
                if ($countones(r) < 2) r = 8'h81;
            end
            repeat ($urandom_range(1, 4)) step(r, 8'($urandom), pick_ready(2));
            if (s == n / 2) do_reset();
        end
    endtask

    task automatic random_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) step(8'h05 << $urandom_range(0, 5), 8'($urandom), pick_ready(2));
                repeat ($urandom_range(1, 3)) step(8'(1 << i), 8'($urandom), pick_ready(2));
            end
        end
    endtask

    initial begin
        row = 8'h00; col = 8'h00; intf.out_ready = 1'b0; reset_n = 1'b0; ovf_seen = 0;
        model_reset();
        repeat (2) @(posedge ph1);
        #1;
        do_reset();

        // Short pair after release must not capture
        step(8'h01, 8'hA0, 1'b1);
        idle(2, 1);

        // Full frame with ready held high
        scan_frame(8'hA0, 4, 1);
        idle(12, 1);
        check_eq("frame1_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure at beat 3
        stall_left = 5;
        scan_frame(8'hA0, 4, 3);
        idle(20, 3);
        check_eq("bp_stall_used", 32'(stall_left), 32'd0);

        // Overflow: two frames with ready low throughout
        do_reset();
        ovf_seen = 0;
        scan_frame(8'hA0, 2, 0);
        scan_frame(8'hB0, 2, 0);
        idle(4, 0);
        check_eq("ovf_pulses", 32'(ovf_seen), 32'd1);
        check_eq("ovf_cnt", 32'(frame_cnt), 32'd1);
        check_eq("ovf_obuf_kept", 32'(intf.out_data), 32'hA0);
        idle(12, 1);

        // Glitches: non-one-hot row held, then a one-cycle row
        repeat (3) step(8'h05, 8'h11, 1'b1);
        step(8'h04, 8'h22, 1'b1);
        idle(2, 1);

        // Out-of-order capture sequence 0,1,3
        step(8'h01, 8'h31, 1'b1); step(8'h01, 8'h31, 1'b1);
        step(8'h02, 8'h32, 1'b1); step(8'h02, 8'h32, 1'b1);
        step(8'h08, 8'h33, 1'b1); step(8'h08, 8'h33, 1'b1);
        idle(3, 1);

        random_frames(40);
        idle(12, 2);
        random_segments(250);
        idle(12, 1);

        // Frame counter wrap
        do_reset();
        for (int f = 0; f < 256; f++) scan_frame(8'($urandom), 2, 1);
        idle(12, 1);
        check_eq("wrap_cnt", 32'(frame_cnt), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_capture.md
Name: scan_capture

Overview:
- Receiving end of the LED-matrix display scan interface (row/col) driven by the display controller.
- Watches the row/col scan, deglitches it, and rebuilds the 8x8 Game-of-Life frame in a capture buffer.
- When a frame is complete, streams it out one row per handshake beat (valid/ready).
- Used for board readback and self-check of displayed generations.

Parameters:
- WIDTH, 8, grid dimension: row/col width, rows per frame.
- REGBITS, 3, row index width (log2 WIDTH).
- STABLE, 2, consecutive sampled cycles a row/col pair must hold before capture (legal range 1..15).

Ports:
- ph1  input  1  single system clock, rising edge; no ph2 in this block.
- reset_n  input  1  asynchronous active-low reset.
- row  input  WIDTH  display row select, one-hot active-high; all-zero = blank.
- col  input  WIDTH  cell data for the selected row, 1 = alive.
- out_valid  output  1  out_addr/out_data hold a valid row beat.
- out_ready  input  1  downstream accepts the beat.
- out_addr  output  REGBITS  row index of the beat.
- out_data  output  WIDTH  row contents of the beat.
- frame_done  output  1  one-cycle pulse: a frame moved to the output buffer.
- frame_cnt  output  8  count of delivered frames, wraps 255->0.
- overflow  output  1  one-cycle pulse: completed frame dropped because output busy.
- scan_err  output  1  one-cycle pulse: row nonzero and not one-hot.

Behaviour:
- Reset (async, reset_n low): every output is 0 (out_valid, out_addr, out_data, frame_done, frame_cnt, overflow, scan_err). Sample register, stability counter, seen mask, captured flag, both buffers, pointer all 0. FSM enters IDLE. Reset mid-stream aborts the frame and drops any pending beats.
- Input stage: row/col registered every edge into s_row/s_col, giving one cycle of latency.
- Stability: counter increments while {s_row,s_col} equals the previous sample, saturating at STABLE. Any change resets it to 1.
- Capture: fires on the edge when the counter reaches STABLE, s_row is one-hot, and the captured flag is clear. It writes cbuf[idx] = s_col, sets seen[idx], and sets the captured flag. The flag clears when the sampled pair changes, so each activation captures exactly once.
- Capture timing: pair applied before edge k, STABLE=2 → captured at edge k+1.
- Blank row (all zero): ignored; clears the captured flag.
- Non-one-hot nonzero s_row: scan_err pulses on the edge it is first sampled; no capture; stability counter forced to 0.
- A row recaptured before frame completion overwrites its cbuf entry (last value wins).
- Frame complete when seen == all ones. On the next edge:
  - If the output side is free (IDLE, or SEND with the final beat handshaking this cycle): obuf <= cbuf, seen <= 0, frame_done=1, frame_cnt++, FSM -> SEND with ptr=0.
  - Else: seen <= 0, overflow=1, frame discarded, frame_cnt unchanged, current output stream unaffected.
- Output FSM:
  - IDLE: out_valid=0.
  - SEND: out_valid=1, out_addr=ptr, out_data=obuf[ptr]. Beat transfers when out_valid&&out_ready; then ptr++. On transfer of ptr==WIDTH-1, go to IDLE (or straight back to SEND ptr=0 if a new frame loads the same edge).
  - out_addr/out_data stable while out_valid && !out_ready; out_valid never drops without a transfer.
- frame_done and out_valid first assert in the same cycle.
- A capture of the first row of the next frame on the completion edge goes into the cleared seen mask (seen = that bit only).

Optional Feature:
- Macro SCAN_ORDER_CHECK_EN.
- Defined:
  - Captures must arrive in ascending index starting at 0 (expected index register, reset 0).
  - An out-of-order capture pulses scan_err, clears seen, and restarts expectation at 0. If the offending row is 0, that capture is kept as the new first row.
  - Completion requires row WIDTH-1 captured after row WIDTH-2.
- Not defined: any capture order is accepted; completion is purely seen == all ones.

Test Plan:
- Reset: hold reset_n=0 with row=8'h01 toggling → all outputs 0. Release → no capture until the pair is stable 2 samples.
- Full frame: rows 0..7 one-hot, col = 8'hA0+i, each held 4 cycles, out_ready=1 → frame_done=1, frame_cnt=1. Then 8 consecutive beats, addr 0..7, data 8'hA0..8'hA7.
- Backpressure: same frame, out_ready=0 for 5 cycles at beat 3 → addr=3, data=8'hA3 held stable; no skipped or duplicated beats.
- Overflow: out_ready=0 throughout, scan two full frames → second frame gives overflow=1, frame_cnt stays 1, obuf still frame 1.
- Glitch/error: row=8'h05 for 3 cycles → scan_err pulse, seen unchanged. row=8'h04 held 1 cycle only (STABLE=2) → no capture.
- Wrap: 256 completed frames → frame_cnt returns to 8'h00. Also with SCAN_ORDER_CHECK_EN, rows 0,1,3 → scan_err and seen cleared.
